// File: rtl/miriscv_ram_hs_if.sv
// rtl/miriscv_ram_hs_if.sv - fetch and data port bundle for miriscv_ram_hs
interface miriscv_ram_hs_if #(
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              instr_req_i;
  logic [31:0]       instr_addr_i;
  logic              instr_rvalid_o;
  logic [DATA_W-1:0] instr_rdata_o;

  logic              data_req_i;
  logic              data_gnt_o;
  logic              data_we_i;
  logic [BYTES-1:0]  data_be_i;
  logic [31:0]       data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_err_o;

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/miriscv_ram_hs.sv
// rtl/miriscv_ram_hs.sv - instruction/data RAM with registered fetch and req/gnt/rvalid data port
module miriscv_ram_hs #(
  parameter int    DATA_W        = 32,
  parameter int    RAM_SIZE      = 4096,
  parameter int    WAIT_CYCLES   = 0,
  parameter string RAM_INIT_FILE = ""
) (
  input logic             clk_i,
  input logic             rst_i,
  miriscv_ram_hs_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = RAM_SIZE / BYTES;
  localparam int AW    = $clog2(RAM_SIZE);
  localparam int OW    = $clog2(BYTES);
  localparam int IW    = AW - OW;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              gnt, accept, data_oor, mem_we;
  logic [IW-1:0]     instr_idx, data_idx;
  logic [DATA_W-1:0] acc_word, pend_rdata, rdata_q, instr_rdata_q;
  logic              pend_err, err_q, instr_rvalid_q;
  logic              unused_addr_bits;

  // The array itself is never reset.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign instr_idx = bus.instr_addr_i[AW-1:OW];
  assign data_idx  = bus.data_addr_i[AW-1:OW];
  assign data_oor  = |bus.data_addr_i[31:AW];
  assign acc_word  = data_oor ? '0 : mem[data_idx];
  assign gnt       = (state != S_WAIT);
  assign accept    = bus.data_req_i & gnt;
  assign mem_we    = accept & bus.data_we_i & ~data_oor;

  assign unused_addr_bits = ^{bus.instr_addr_i[31:AW], bus.instr_addr_i[OW-1:0],
                              bus.data_addr_i[OW-1:0]};

  always @(posedge clk_i) begin
    for (int k = 0; k < BYTES; k++) begin
      if (mem_we && bus.data_be_i[k]) mem[data_idx][k*8 +: 8] <= bus.data_wdata_i[k*8 +: 8];
    end
  end

  // Fetch reads the array before any same-edge data write lands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_rvalid_q <= 1'b0;
      instr_rdata_q  <= '0;
    end else begin
      instr_rvalid_q <= bus.instr_req_i;
      if (bus.instr_req_i) instr_rdata_q <= mem[instr_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_n = S_RESP;
          end else begin
            state_n = S_WAIT;
            cnt_n   = CNT_INIT;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_n = S_RESP;
        else             cnt_n   = cnt - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Access result is captured at accept and exposed only when RESP is entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_rdata <= '0;
      pend_err   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        pend_rdata <= acc_word;
        pend_err   <= data_oor;
      end
      if (accept && WAIT_CYCLES == 0) begin
        rdata_q <= acc_word;
        err_q   <= data_oor;
      end else if (state == S_WAIT && cnt == 4'd0) begin
        rdata_q <= pend_rdata;
        err_q   <= pend_err;
      end
    end
  end

  assign bus.instr_rvalid_o = instr_rvalid_q;
  assign bus.instr_rdata_o  = instr_rdata_q;
  assign bus.data_gnt_o     = gnt;
  assign bus.data_rvalid_o  = (state == S_RESP);
  assign bus.data_rdata_o   = rdata_q;
  assign bus.data_err_o     = (state == S_RESP) & err_q;
endmodule
